// File: rtl/uart_tx_buffered_pkg.sv
// Shared definitions for the buffered UART transmit path: parity encodings,
// transmitter FSM states and a baud divisor helper.
package uart_tx_buffered_pkg;

    localparam int UART_PARITY_NONE = 0;
    localparam int UART_PARITY_ODD  = 1;
    localparam int UART_PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP  = 3'd4
    } tx_state_e;

    // Rounded clock-cycles-per-bit for a clock/baud pair,
    // e.g. baud_div(100_000_000, 115_200) = 868.
    function automatic int baud_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_tx_buffered_sync_fifo.sv
// Single-clock FIFO with occupancy count. Full/empty come from the count so
// the pointers can simply wrap. Read data is the current head (show-ahead).
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; push and pop together leave count alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (do_push && !do_pop)      count <= count + CNT_ONE;
            else if (do_pop && !do_push) count <= count - CNT_ONE;
        end
    end

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// UART transmitter fed from an internal FIFO. Frames are serialised back to
// back; the next word is popped on the last cycle of the final stop bit so no
// idle cycle appears between frames.
module uart_tx_buffered
    import uart_tx_buffered_pkg::*;
#(
    parameter int CLKS_PER_BAUD = 868,
    parameter int DATA_BITS     = 8,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1,
    parameter int FIFO_DEPTH    = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_valid,
    input  logic [DATA_BITS-1:0]          i_data,
    output logic                          o_ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_count,
    output logic                          o_busy,
    output logic                          o_uart_tx
);

    localparam logic [15:0] BAUD_RELOAD = 16'(CLKS_PER_BAUD - 1);
    localparam logic [15:0] BAUD_ONE    = 16'd1;
    localparam logic [2:0]  DATA_LAST   = 3'(DATA_BITS - 1);
    localparam logic [2:0]  STOP_LAST   = 3'(STOP_BITS - 1);
    localparam logic        PAR_INIT    = (PARITY == UART_PARITY_ODD);

    tx_state_e              state, state_nx;
    logic [15:0]            baud_cnt, baud_nx;
    logic [2:0]             bit_cnt, bit_nx;
    logic [DATA_BITS-1:0]   shreg, sh_nx;
    logic                   par, par_nx;
    logic                   tx, tx_nx;
    logic                   start_frame;
    logic                   bit_end;

    logic                   fifo_pop;
    logic [DATA_BITS-1:0]   fifo_rdata;
    logic                   fifo_full;
    logic                   fifo_empty;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .rst   (i_rst),
        .push  (i_valid),
        .wdata (i_data),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (o_count)
    );

    // Ready depends only on occupancy, never on i_valid.
    assign o_ready   = !fifo_full;
    assign o_busy    = (state != ST_IDLE) || !fifo_empty;
    assign o_uart_tx = tx;
    assign bit_end   = (baud_cnt == '0);

    // State and datapath registers; reset aborts any frame and idles the line.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par      <= 1'b0;
            tx       <= 1'b1;
        end else begin
            state    <= state_nx;
            baud_cnt <= baud_nx;
            bit_cnt  <= bit_nx;
            shreg    <= sh_nx;
            par      <= par_nx;
            tx       <= tx_nx;
        end
    end

    // Next-state logic: counts down each bit period, then advances the frame
    // and presents the next line level so the output stays registered.
    always_comb begin
        state_nx    = state;
        baud_nx     = baud_cnt;
        bit_nx      = bit_cnt;
        sh_nx       = shreg;
        par_nx      = par;
        tx_nx       = tx;
        fifo_pop    = 1'b0;
        start_frame = 1'b0;

        if (state == ST_IDLE) begin
            tx_nx = 1'b1;
            if (!fifo_empty) start_frame = 1'b1;
        end else if (!bit_end) begin
            baud_nx = baud_cnt - BAUD_ONE;
        end else begin
            baud_nx = BAUD_RELOAD;
            case (state)
                ST_START: begin
                    state_nx = ST_DATA;
                    tx_nx    = shreg[0];
                    par_nx   = par ^ shreg[0];
                    sh_nx    = shreg >> 1;
                    bit_nx   = '0;
                end
                ST_DATA: begin
                    if (bit_cnt == DATA_LAST) begin
                        bit_nx = '0;
                        if (PARITY != UART_PARITY_NONE) begin
                            state_nx = ST_PAR;
                            tx_nx    = par;
                        end else begin
                            state_nx = ST_STOP;
                            tx_nx    = 1'b1;
                        end
                    end else begin
                        bit_nx = bit_cnt + 3'd1;
                        tx_nx  = shreg[0];
                        par_nx = par ^ shreg[0];
                        sh_nx  = shreg >> 1;
                    end
                end
                ST_PAR: begin
                    state_nx = ST_STOP;
                    tx_nx    = 1'b1;
                    bit_nx   = '0;
                end
                ST_STOP: begin
                    tx_nx = 1'b1;
                    if (bit_cnt == STOP_LAST) begin
                        if (!fifo_empty) start_frame = 1'b1;
                        else             state_nx    = ST_IDLE;
                    end else begin
                        bit_nx = bit_cnt + 3'd1;
                    end
                end
                default: begin
                    state_nx = ST_IDLE;
                    tx_nx    = 1'b1;
                end
            endcase
        end

        // Pop the head word and begin its start bit on this same edge.
        if (start_frame) begin
            fifo_pop = 1'b1;
            state_nx = ST_START;
            tx_nx    = 1'b0;
            baud_nx  = BAUD_RELOAD;
            bit_nx   = '0;
            sh_nx    = fifo_rdata;
            par_nx   = PAR_INIT;
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: an 8N1 instance carries the scoreboard traffic,
// two 7-bit/2-stop instances cover even and odd parity framing.
module tb_uart_tx_buffered;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 8N1, CLKS_PER_BAUD=4, depth 16
    logic       a_valid = 1'b0;
    logic [7:0] a_data  = '0;
    logic       a_ready, a_busy, a_tx;
    logic [4:0] a_count;
    // 7E2
    logic       b_valid = 1'b0;
    logic [6:0] b_data  = '0;
    logic       b_ready, b_busy, b_tx;
    logic [4:0] b_count;
    // 7O2
    logic       c_valid = 1'b0;
    logic [6:0] c_data  = '0;
    logic       c_ready, c_busy, c_tx;
    logic [2:0] c_count;

    uart_tx_buffered #(.CLKS_PER_BAUD(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_valid(a_valid), .i_data(a_data),
        .o_ready(a_ready), .o_count(a_count), .o_busy(a_busy), .o_uart_tx(a_tx));

    uart_tx_buffered #(.CLKS_PER_BAUD(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(16)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_valid(b_valid), .i_data(b_data),
        .o_ready(b_ready), .o_count(b_count), .o_busy(b_busy), .o_uart_tx(b_tx));

    uart_tx_buffered #(.CLKS_PER_BAUD(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_c (
        .i_clk(clk), .i_rst(rst), .i_valid(c_valid), .i_data(c_data),
        .o_ready(c_ready), .o_count(c_count), .o_busy(c_busy), .o_uart_tx(c_tx));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] sb_q[$];
    int         start_q[$];
    logic [9:0] raw_q[$];

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // frame[i] = line level in bit slot i
    } vec_t;

    // Cycle counter used to time-stamp frame starts.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Serial monitor on dut_a: checks every bit is exactly 4 cycles, stop bit
    // high, and that decoded data matches the scoreboard head.
    initial begin : mon
        logic [9:0] f;
        bit         abort;
        bit         glitch;
        int         st;
        forever begin
            @(negedge clk);
            if (!rst && a_tx == 1'b0) begin
                st = cyc; abort = 0; glitch = 0; f = '0;
                for (int b = 0; b < 10 && !abort; b++) begin
                    for (int c = 0; c < 4 && !abort; c++) begin
                        if (b != 0 || c != 0) @(negedge clk);
                        if (rst) abort = 1;
                        else if (c == 0) f[b] = a_tx;
                        else if (a_tx != f[b]) glitch = 1;
                    end
                end
                if (!abort) begin
                    check("frame_stable_stop", {glitch, f[9]}, 32'h1);
                    if (sb_q.size() == 0) check("frame_unexpected", 1, 0);
                    else check("frame_data", f[8:1], sb_q.pop_front());
                    start_q.push_back(st);
                    raw_q.push_back(f);
                end
            end
        end
    end

    // Waits for o_ready, optionally scrambling i_data while stalled, then pushes.
    task automatic push_a(input logic [7:0] w, input bit junk, output bit stalled, output int stall_cnt);
        int n;
        stalled = 0; stall_cnt = -1; n = 0;
        @(negedge clk);
        while (!a_ready && n < 5000) begin
            if (!stalled) stall_cnt = int'(a_count);
            stalled = 1;
            a_valid = 1'b1;
            a_data  = junk ? 8'($urandom) : w;
            n++;
            @(negedge clk);
        end
        if (!a_ready) begin
            check("push_timeout", 0, 1);
            a_valid = 1'b0;
            return;
        end
        a_valid = 1'b1;
        a_data  = w;
        sb_q.push_back(w);
        @(posedge clk);
    endtask

    task automatic wait_idle_a(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while ((a_busy || a_count != 0) && n < 3000) begin
            n++;
            @(negedge clk);
        end
        check(name, a_busy, 0);
        @(negedge clk);
    endtask

    task automatic run_fmt(input bit use_c, output logic [10:0] slots, output int len);
        slots = '0; len = 0;
        @(negedge clk);
        if (use_c) begin c_valid = 1'b1; c_data = 7'h03; end
        else       begin b_valid = 1'b1; b_data = 7'h03; end
        @(posedge clk);
        @(negedge clk);
        b_valid = 1'b0; c_valid = 1'b0;
        @(negedge clk);
        while ((use_c ? c_busy : b_busy) && len < 200) begin
            if (len % 4 == 0 && len / 4 < 11) slots[len/4] = use_c ? c_tx : b_tx;
            len++;
            @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t       vt[6];
        bit         st;
        int         sc;
        bit         stall_seen;
        int         first_stall;
        int         base;
        int         n;
        int         gaps;
        logic [10:0] slots;
        int         len;

        vt[0] = '{8'hA5, 10'b1101001010};
        vt[1] = '{8'h00, 10'b1000000000};
        vt[2] = '{8'hFF, 10'b1111111110};
        vt[3] = '{8'h01, 10'b1000000010};
        vt[4] = '{8'h80, 10'b1100000000};
        vt[5] = '{8'h3C, 10'b1001111000};

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_tx",    a_tx,    1);
        check("rst_ready", a_ready, 1);
        check("rst_count", a_count, 0);
        check("rst_busy",  a_busy,  0);
        check("rst_b_tx",  b_tx,    1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single-word table, first entry also checks latency and busy width
        for (int i = 0; i < 6; i++) begin
            base = raw_q.size();
            push_a(vt[i].data, 0, st, sc);
            @(negedge clk);
            a_valid = 1'b0;
            if (i == 0) begin
                check("lat_count1", a_count, 1);
                check("lat_tx_idle", a_tx, 1);
                check("lat_busy_queued", a_busy, 1);
                @(negedge clk);
                check("lat_tx_start", a_tx, 0);
                check("lat_count0", a_count, 0);
                n = 0;
                while (a_busy && n < 200) begin
                    n++;
                    @(negedge clk);
                end
                check("busy_frame_cycles", n, 40);
            end
            wait_idle_a("single_idle");
            check("single_frame_cnt", raw_q.size(), base + 1);
            if (raw_q.size() > base) check("single_frame_bits", raw_q[base], vt[i].frame);
        end

        // Parity / format on the 7-bit instances
        run_fmt(0, slots, len);
        check("even_frame", slots, 11'b11000000110);
        check("even_par",   slots[8], 0);
        check("even_len",   len, 44);
        run_fmt(1, slots, len);
        check("odd_frame", slots, 11'b11100000110);
        check("odd_par",   slots[8], 1);
        check("odd_len",   len, 44);

        // Burst of 20 with data scrambled while stalled on full
        base = start_q.size();
        stall_seen = 0; first_stall = -1;
        for (int i = 0; i < 20; i++) begin
            push_a(8'(8'h10 + i * 7), 1, st, sc);
            if (st && !stall_seen) begin
                stall_seen  = 1;
                first_stall = sc;
            end
        end
        @(negedge clk);
        a_valid = 1'b0;
        wait_idle_a("burst_idle");
        check("burst_stalled", stall_seen, 1);
        check("burst_full_count", first_stall, 16);
        check("burst_frames", start_q.size(), base + 20);
        gaps = 0;
        for (int i = base + 1; i < start_q.size(); i++)
            if (start_q[i] - start_q[i-1] != 40) gaps++;
        check("burst_no_gap", gaps, 0);

        // Push on the same edge as a frame-end pop with three words held
        for (int i = 0; i < 4; i++) push_a(8'(8'hC0 + i), 0, st, sc);
        @(negedge clk);
        a_valid = 1'b0;
        repeat (37) @(negedge clk);
        check("simul_cnt_before", a_count, 3);
        a_valid = 1'b1;
        a_data  = 8'h5A;
        sb_q.push_back(8'h5A);
        @(posedge clk);
        @(negedge clk);
        a_valid = 1'b0;
        check("simul_cnt_after", a_count, 3);
        check("simul_new_start", a_tx, 0);

        // More traffic so pointers wrap well past 40 words
        for (int i = 0; i < 12; i++) push_a(8'($urandom), 0, st, sc);
        @(negedge clk);
        a_valid = 1'b0;
        wait_idle_a("wrap_idle");
        check("sb_drained", sb_q.size(), 0);

        // Reset in the middle of a frame with queued words
        for (int i = 0; i < 5; i++) push_a(8'h00, 0, st, sc);
        @(negedge clk);
        a_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_tx_low", a_tx, 0);
        #1 rst = 1'b1;
        sb_q.delete();
        #1;
        check("arst_tx",    a_tx,    1);
        check("arst_count", a_count, 0);
        check("arst_busy",  a_busy,  0);
        check("arst_ready", a_ready, 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (a_tx === 1'b1 && a_busy === 1'b0) n++;
        end
        check("post_rst_quiet", n, 60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
